// File: rtl/ring_cadence_pkg.sv
// Shared cadence definitions: FSM state encodings and the default burst/gap lengths
// that call control also uses.
package ring_cadence_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_ON_CYC  = 800;
    localparam int DEF_OFF_CYC = 400;

endpackage

// File: rtl/ring_cadence_gen_cadence_timer.sv
// Cycle counter for tone bursts and gaps: counts up from 0 and flags when it reaches
// the loaded terminal value, then restarts from 0 on the following edge.
module cadence_timer
    import ring_cadence_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clkout,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] load,
    output logic             term
);

    logic [CNT_W-1:0] cnt;

    assign term = (cnt == load);

    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ring_cadence_gen.sv
// Ring cadence sequencer: plays N square-wave bursts separated by silent gaps, then
// pulses done. Optional abort input is enabled by defining RING_ABORT_EN.
module ring_cadence_gen
    import ring_cadence_pkg::*;
#(
    parameter int ON_CYC  = DEF_ON_CYC,
    parameter int OFF_CYC = DEF_OFF_CYC,
    parameter int CNT_W   = 20,
    parameter int RING_W  = 4
) (
    input  logic              clkout,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RING_W-1:0] rings,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [RING_W-1:0] ring_idx,
    output logic              beep
);

    state_t            state, state_nx;
    logic              beep_nx, done_nx;
    logic [RING_W-1:0] ring_idx_nx, rings_q, rings_q_nx;
    logic              term, clear, abort_go;
    logic [CNT_W-1:0]  load;

`ifdef RING_ABORT_EN
    assign abort_go = abort && (state != ST_IDLE);
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_go     = 1'b0;
`endif

    // One timer serves both phases; its count is held at 0 while idle or aborting.
    assign load  = (state == ST_GAP) ? CNT_W'(OFF_CYC - 1) : CNT_W'(ON_CYC - 1);
    assign clear = (state == ST_IDLE) || abort_go;
    assign busy  = (state == ST_TONE) || (state == ST_GAP);

    cadence_timer #(.CNT_W(CNT_W)) u_timer (
        .clkout (clkout),
        .rst_n  (rst_n),
        .clear  (clear),
        .load   (load),
        .term   (term)
    );

    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beep     <= 1'b0;
            done     <= 1'b0;
            ring_idx <= '0;
            rings_q  <= '0;
        end else begin
            state    <= state_nx;
            beep     <= beep_nx;
            done     <= done_nx;
            ring_idx <= ring_idx_nx;
            rings_q  <= rings_q_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        beep_nx     = beep;
        done_nx     = 1'b0;
        ring_idx_nx = ring_idx;
        rings_q_nx  = rings_q;
        case (state)
            ST_IDLE: begin
                beep_nx = 1'b0;
                if (start) begin
                    if (rings != '0) begin
                        rings_q_nx  = rings;
                        ring_idx_nx = '0;
                        state_nx    = ST_TONE;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            ST_TONE: begin
                if (term) begin
                    beep_nx = 1'b0;
                    // Last ring ends straight into IDLE with no trailing gap.
                    if ((ring_idx + 1'b1) == rings_q) begin
                        state_nx    = ST_IDLE;
                        done_nx     = 1'b1;
                        ring_idx_nx = '0;
                    end else begin
                        state_nx    = ST_GAP;
                        ring_idx_nx = ring_idx + 1'b1;
                    end
                end else begin
                    beep_nx = ~beep;
                end
            end
            ST_GAP: begin
                beep_nx = 1'b0;
                if (term) begin
                    state_nx = ST_TONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                beep_nx  = 1'b0;
            end
        endcase
        if (abort_go) begin
            state_nx    = ST_IDLE;
            beep_nx     = 1'b0;
            ring_idx_nx = '0;
            done_nx     = 1'b1;
        end
    end

endmodule
